multicycle_mips_core: RTL
=========================

Name: multicycle_mips_core

Overview:
- Multi-cycle MIPS core that replaces the single-cycle processor's combinational fetch/execute path with an FSM.
- Instruction and data memories are accessed through req/ready handshakes, so both may have arbitrary latency.
- Register file (32x32) is internal. Data-memory address width and reset PC are parametrised.
- Sits between the instruction ROM and the data SRAM wrapper in the testbench/top.

Parameters:
DATA_ADDR_W, 7, data-memory word-address width; D_addr = ALU result bits [DATA_ADDR_W+1:2]
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
I_req  output  1  instruction fetch request
I_addr  output  32  fetch byte address (PC)
I_ready  input  1  fetch complete; IR valid this cycle
IR  input  32  instruction word
D_req  output  1  data access request
D_wen  output  1  1 = write (sw), 0 = read (lw); valid while D_req=1
D_addr  output  DATA_ADDR_W  data word address
D_wdata  output  32  store data (rt value)
D_rdata  input  32  load data; valid when D_ready=1 and D_wen=0
D_ready  input  1  data access complete
RF_writedata  output  32  value written to the register file this cycle
RF_we  output  1  register-file write strobe (never set for $0)
retire  output  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-low on rst_n. Asserting rst_n=0 clears all 32 registers, sets PC=RESET_PC, state=FETCH, and drives every output to 0. I_addr reads RESET_PC once reset is released.
- Reset mid-access aborts the access immediately. req drops asynchronously.
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - I_req=1, I_addr=PC, both held stable until I_ready is sampled 1.
  - On that edge, latch IR into the internal instruction register and go to DECODE.
  - I_req is 0 in DECODE.
- DECODE: read rs and rt into A/B latches; compute PC+4; go to EXEC.
- EXEC, by opcode:
  - R-type (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt): compute ALUout, go to WB.
  - lw/sw: ALUout = A + signext(imm16), go to MEM.
  - beq: PC = (A==B) ? PC+4+(signext(imm16)<<2) : PC+4; retire; go to FETCH.
  - j: PC = {PC+4[31:28], IR[25:0], 2'b00}; retire; go to FETCH.
  - jal: same PC as j; $31 = PC+4 (RF_we=1); retire; go to FETCH.
  - jr (R-type funct 0x08): PC = A; retire; go to FETCH.
  - Any other opcode/funct: NOP, PC = PC+4; retire; go to FETCH.
- MEM:
  - D_req=1, D_addr=ALUout[DATA_ADDR_W+1:2], D_wen=(sw), D_wdata=B. All held stable until D_ready is sampled 1.
  - ALUout bits [1:0] are ignored; no misalignment trap.
  - sw: on D_ready, PC=PC+4, retire, go to FETCH.
  - lw: on D_ready, latch D_rdata into MDR, go to WB.
- WB:
  - Write ALUout (R-type, to rd) or MDR (lw, to rt).
  - RF_we=1, RF_writedata = written value, PC=PC+4, retire, go to FETCH.
- Writes to $0 are suppressed (RF_we=0) and $0 always reads 0. RF_writedata still shows the computed value.
- Latency with zero-wait memories (I_ready/D_ready high in the first req cycle):
  - R-type 4 cycles; lw 5; sw 4; beq/j/jal/jr/NOP 3.
  - Each wait cycle adds one.
- I_ready/D_ready are ignored while the corresponding req=0.
- Arithmetic: 32-bit two's-complement, overflow ignored (add/sub wrap); slt is a signed comparison.
- PC wraps modulo 2^32.
- RF_we, RF_writedata and retire are 0 in every cycle not listed above.

Optional Feature:
IMM_ALU_EN
- Defined: EXEC also decodes addi (0x08, sign-extended), andi (0x0C, zero-extended), ori (0x0D, zero-extended), slti (0x0A, signed, sign-extended). Each goes to WB and writes rt: 4 cycles.
- Undefined: these opcodes are treated as NOP (3 cycles, no register write).

Test Plan:
- Reset then release, zero-wait memories -> first I_addr=RESET_PC; I_req=1 on the first cycle; all other outputs 0 during reset.
- add $3,$1,$2 with $1=5, $2=-7, zero-wait -> RF_writedata=32'hFFFF_FFFE, RF_we=1 in cycle 4, retire in cycle 4, next I_addr=PC+4.
- sw $2,8($0) then lw $4,8($0), D_ready delayed 3 cycles each ->
  - store: D_addr=2, D_wen=1, D_wdata held for 4 cycles.
  - load: RF_writedata=stored value in cycle 8 of the load; total lw latency 8.
- beq taken at PC=0x10 with imm=-4 -> next I_addr=0x04. Not-taken -> 0x14. Each takes 3 cycles.
- jal at PC=0x40 to target 0x100, then jr $31 -> $31=0x44, fetch 0x100, then fetch 0x44.
- Write to $0 (add $0,$1,$1), then rst_n pulsed low during a stalled fetch ->
  - $0 still reads 0 and RF_we stays 0.
  - I_req drops immediately and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB FSM with req/ready instruction and data ports.
// Optional macro IMM_ALU_EN adds addi/andi/ori/slti; without it those opcodes retire as NOPs.
module multicycle_mips_core #(
    parameter int unsigned DATA_ADDR_W = 7,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   I_req,
    output logic [31:0]            I_addr,
    input  logic                   I_ready,
    input  logic [31:0]            IR,
    output logic                   D_req,
    output logic                   D_wen,
    output logic [DATA_ADDR_W-1:0] D_addr,
    output logic [31:0]            D_wdata,
    input  logic [31:0]            D_rdata,
    input  logic                   D_ready,
    output logic [31:0]            RF_writedata,
    output logic                   RF_we,
    output logic                   retire
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] F_JR  = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2A;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic        i_req_c, d_req_c, rf_we_c, retire_c;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata_c;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, pc_plus4, jump_target;

    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign funct       = ir_q[5:0];
    assign imm_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {pc_plus4[31:28], ir_q[25:0], 2'b00};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        rf_d       = rf_q;
        i_req_c    = 1'b0;
        d_req_c    = 1'b0;
        rf_we_c    = 1'b0;
        rf_waddr   = 5'd0;
        rf_wdata_c = 32'd0;
        retire_c   = 1'b0;

        case (state_q)
            S_FETCH: begin
                i_req_c = 1'b1;
                if (I_ready) begin
                    ir_d    = IR;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = (rs == 5'd0) ? 32'd0 : rf_q[rs];
                b_d     = (rt == 5'd0) ? 32'd0 : rf_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Control-flow and unknown ops retire here; ALU and memory ops override below.
                state_d  = S_FETCH;
                retire_c = 1'b1;
                pc_d     = pc_plus4;
                case (opcode)
                    OP_RTYPE: begin
                        state_d  = S_WB;
                        retire_c = 1'b0;
                        pc_d     = pc_q;
                        case (funct)
                            F_ADD: alu_d = a_q + b_q;
                            F_SUB: alu_d = a_q - b_q;
                            F_AND: alu_d = a_q & b_q;
                            F_OR:  alu_d = a_q | b_q;
                            F_SLT: alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                            F_JR: begin
                                state_d  = S_FETCH;
                                retire_c = 1'b1;
                                pc_d     = a_q;
                            end
                            default: begin
                                state_d  = S_FETCH;
                                retire_c = 1'b1;
                                pc_d     = pc_plus4;
                            end
                        endcase
                    end
                    OP_LW, OP_SW: begin
                        alu_d    = a_q + imm_sext;
                        state_d  = S_MEM;
                        retire_c = 1'b0;
                        pc_d     = pc_q;
                    end
                    OP_BEQ: pc_d = (a_q == b_q) ? pc_plus4 + {imm_sext[29:0], 2'b00} : pc_plus4;
                    OP_J:   pc_d = jump_target;
                    OP_JAL: begin
                        pc_d       = jump_target;
                        rf_we_c    = 1'b1;
                        rf_waddr   = 5'd31;
                        rf_wdata_c = pc_plus4;
                    end
`ifdef IMM_ALU_EN
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                        state_d  = S_WB;
                        retire_c = 1'b0;
                        pc_d     = pc_q;
                        case (opcode)
                            OP_ADDI: alu_d = a_q + imm_sext;
                            OP_ANDI: alu_d = a_q & {16'd0, ir_q[15:0]};
                            OP_ORI:  alu_d = a_q | {16'd0, ir_q[15:0]};
                            default: alu_d = {31'd0, $signed(a_q) < $signed(imm_sext)};
                        endcase
                    end
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                d_req_c = 1'b1;
                if (D_ready) begin
                    if (opcode == OP_SW) begin
                        pc_d     = pc_plus4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = D_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c    = 1'b1;
                rf_waddr   = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata_c = (opcode == OP_LW) ? mdr_q : alu_q;
                pc_d       = pc_plus4;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (rf_we_c && rf_waddr != 5'd0) rf_d[rf_waddr] = rf_wdata_c;
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            // NOTE: the register file is architecturally cleared on reset, so it lives in flops, not RAM.
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            rf_q    <= rf_d;
        end
    end

    // Outputs are gated by rst_n so a reset aborts any request in the same instant.
    assign I_req        = rst_n & i_req_c;
    assign I_addr       = rst_n ? pc_q : 32'd0;
    assign D_req        = rst_n & d_req_c;
    assign D_wen        = rst_n & d_req_c & (opcode == OP_SW);
    assign D_addr       = (rst_n & d_req_c) ? alu_q[DATA_ADDR_W+1:2] : '0;
    assign D_wdata      = (rst_n & d_req_c) ? b_q : 32'd0;
    assign RF_we        = rst_n & rf_we_c & (rf_waddr != 5'd0);
    assign RF_writedata = rst_n ? rf_wdata_c : 32'd0;
    assign retire       = rst_n & retire_c;

endmodule
